// File: rtl/systol_pkg.sv
// Shared constants and the result reader's state encoding for the systolic array slice.
package systol_pkg;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        WAIT = 3'd2,
        SEND = 3'd3,
        DONE = 3'd4,
        CSUM = 3'd5
    } reader_state_t;

endpackage

// File: rtl/result_stream_reader_if.sv
// Result-memory read port plus the valid/ready byte stream toward the UART transmitter.
import systol_pkg::*;

interface result_stream_reader_if;
    // Memory port: rd_data is valid one cycle after rd_en.
    // Stream: a byte moves on a rising edge where tx_valid && tx_ready; while tx_valid is
    // high and tx_ready is low, tx_data stays stable and tx_valid stays high.
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport master (
        output rd_en, rd_addr, tx_data, tx_valid,
        input  rd_data, tx_ready
    );

    modport slave (
        input  rd_en, rd_addr, tx_data, tx_valid,
        output rd_data, tx_ready
    );

endinterface

// File: rtl/result_stream_reader.sv
// Dumps a contiguous, wrapping range of result memory as a byte stream to the UART TX path.
// Define CHECKSUM_EN to append an 8-bit running-sum trailer byte after each dump.
import systol_pkg::*;

module result_stream_reader #(
    parameter int RD_LAT = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       base_addr,
    input  logic [ADDR_W:0]         len,
    result_stream_reader_if.master  bus,
    output logic                    busy,
    output logic                    done,
    output reader_state_t           dbg_state
);

    if (RD_LAT != 1) begin : g_bad_rd_lat
        $error("result_stream_reader supports only RD_LAT == 1");
    end

    reader_state_t     r_state;
    reader_state_t     w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_remaining;
    logic [DATA_W-1:0] r_tx_data;
    logic              r_tx_valid;
    logic              w_accept;
    logic              w_handshake;
    logic              w_last;
`ifdef CHECKSUM_EN
    logic [7:0]        r_sum;
`endif

    assign w_handshake = r_tx_valid && bus.tx_ready;
    assign w_last      = (r_remaining == (ADDR_W+1)'(1));

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    if (len == '0) begin
`ifdef CHECKSUM_EN
                        w_next = CSUM;
`else
                        w_next = DONE;
`endif
                    end else begin
                        w_next = READ;
                    end
                end
            end
            READ: w_next = WAIT;
            WAIT: w_next = SEND;
            SEND: begin
                if (w_handshake) begin
                    if (w_last) begin
`ifdef CHECKSUM_EN
                        w_next = CSUM;
`else
                        w_next = DONE;
`endif
                    end else begin
                        w_next = READ;
                    end
                end
            end
`ifdef CHECKSUM_EN
            CSUM: if (w_handshake) w_next = DONE;
`endif
            DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr      <= '0;
            r_remaining <= '0;
            r_tx_data   <= '0;
            r_tx_valid  <= 1'b0;
`ifdef CHECKSUM_EN
            r_sum       <= '0;
`endif
        end else begin
            if (w_accept) begin
                r_addr      <= base_addr;
                r_remaining <= len;
            end
            if (r_state == WAIT) begin
                r_tx_data  <= bus.rd_data;
                r_tx_valid <= 1'b1;
            end
            if (r_state == SEND && w_handshake) begin
                r_addr      <= r_addr + 1'b1;
                r_remaining <= r_remaining - 1'b1;
                r_tx_valid  <= 1'b0;
            end
`ifdef CHECKSUM_EN
            if (w_accept)
                r_sum <= '0;
            else if (r_state == SEND && w_handshake)
                r_sum <= r_sum + r_tx_data;
            // The trailer must include the byte being accepted this very cycle.
            if (w_next == CSUM && r_state != CSUM) begin
                r_tx_data  <= (r_state == SEND) ? (r_sum + r_tx_data) : '0;
                r_tx_valid <= 1'b1;
            end
            if (r_state == CSUM && w_handshake)
                r_tx_valid <= 1'b0;
`endif
        end
    end

    assign bus.rd_en    = (r_state == READ);
    assign bus.rd_addr  = r_addr;
    assign bus.tx_data  = r_tx_data;
    assign bus.tx_valid = r_tx_valid;
    assign busy         = (r_state != IDLE);
    assign done         = (r_state == DONE);
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_result_stream_reader.sv
// Directed and randomized dumps checked against a queue-based model of the byte stream.
`timescale 1ns/1ps
import systol_pkg::*;

module tb_result_stream_reader;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   len;
    logic              busy;
    logic              done;
    reader_state_t     dbg_state;

    result_stream_reader_if bus();

    result_stream_reader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    always @(posedge clk) begin
        if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
    end

    int errors = 0;
    int checks = 0;
    logic [DATA_W-1:0] exp_q[$];
    logic [ADDR_W-1:0] exp_addr_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // mode 0: ready tied high, 1: random ready, 2: ready low for 'stall' valid cycles per byte
    // extra 1: second start during SEND, 2: start in the DONE cycle
    task automatic run_dump(input logic [ADDR_W-1:0] b, input int n, input int mode,
                            input int stall, input int extra);
        logic [7:0]        sum;
        logic [ADDR_W-1:0] a;
        int cyc, first_valid, exp_first, rd_cnt, done_cyc, wcnt, budget, busy_bad;
        logic done_seen, ready, prev_valid, prev_ready, restart_active;
        logic [DATA_W-1:0] prev_data;

        exp_q.delete();
        exp_addr_q.delete();
        sum = 8'h00;
        a = b;
        for (int i = 0; i < n; i++) begin
            exp_addr_q.push_back(a);
            exp_q.push_back(mem[a]);
            sum = sum + mem[a];
            a = a + 1'b1;
        end
`ifdef CHECKSUM_EN
        exp_q.push_back(sum);
        exp_first = (n == 0) ? 1 : 3;
`else
        exp_first = (n == 0) ? -1 : 3;
`endif

        bus.tx_ready = (mode == 0);
        base_addr = b;
        len = (ADDR_W+1)'(n);
        start = 1'b1;
        tick();
        start = 1'b0;

        cyc = 0; first_valid = -1; rd_cnt = 0; done_cyc = -1; wcnt = 0; busy_bad = 0;
        done_seen = 1'b0; prev_valid = 1'b0; prev_ready = 1'b0; prev_data = '0;
        restart_active = 1'b0;
        budget = 20 * (n + 2) + 50;

        while (cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (restart_active) begin
                start = 1'b0;
                restart_active = 1'b0;
            end
            if (!busy) busy_bad++;
            if (bus.rd_en) begin
                rd_cnt++;
                if (exp_addr_q.size() == 0) check("extra_rd_en", 1, 0);
                else check("rd_addr", bus.rd_addr, exp_addr_q.pop_front());
            end
            if (done) begin
                done_seen = 1'b1;
                done_cyc = cyc;
                break;
            end
            if (prev_valid && !prev_ready) begin
                check("hold_valid", bus.tx_valid, 1);
                check("hold_data", bus.tx_data, prev_data);
            end
            if (bus.tx_valid && first_valid < 0) begin
                first_valid = cyc;
                if (extra == 1) begin
                    base_addr = b + 14'h0100;
                    len = (ADDR_W+1)'(7);
                    start = 1'b1;
                    restart_active = 1'b1;
                end
            end
            case (mode)
                0: ready = 1'b1;
                1: ready = 1'($urandom_range(0, 1));
                default: begin
                    if (bus.tx_valid) wcnt++;
                    ready = bus.tx_valid && (wcnt > stall);
                end
            endcase
            if (bus.tx_valid && ready) begin
                wcnt = 0;
                if (exp_q.size() == 0) check("extra_byte", 1, 0);
                else check("tx_data", bus.tx_data, exp_q.pop_front());
            end
            prev_valid = bus.tx_valid;
            prev_ready = ready;
            prev_data  = bus.tx_data;
            bus.tx_ready = ready;
        end

        check("done_seen", done_seen, 1);
        check("bytes_left", exp_q.size(), 0);
        check("reads_left", exp_addr_q.size(), 0);
        check("rd_count", rd_cnt, n);
        check("first_valid_cycle", first_valid, exp_first);
        check("busy_during_dump", busy_bad, 0);
`ifndef CHECKSUM_EN
        if (n == 0) check("zero_len_done_cycle", done_cyc, 1);
`endif

        if (extra == 2) begin
            base_addr = b;
            len = (ADDR_W+1)'(3);
            start = 1'b1;
        end
        @(negedge clk);
        start = 1'b0;
        check("post_busy", busy, 0);
        check("post_done", done, 0);
        check("post_tx_valid", bus.tx_valid, 0);
        @(negedge clk);
        check("post2_busy", busy, 0);
        check("post2_rd_en", bus.rd_en, 0);
        check("post2_done", done, 0);
        bus.tx_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        start = 1'b0;
        base_addr = '0;
        len = '0;
        bus.tx_ready = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("rst_rd_en", bus.rd_en, 0);
        check("rst_rd_addr", bus.rd_addr, 0);
        check("rst_tx_data", bus.tx_data, 0);
        check("rst_tx_valid", bus.tx_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_state", dbg_state, IDLE);
        tick();
        rst = 1'b0;
        tick();

        // basic dump
        for (int i = 0; i < 4; i++) mem[i] = DATA_W'(i + 1);
        run_dump(14'h0000, 4, 0, 0, 0);

        // backpressure
        mem[14'h0010] = 8'hAA;
        mem[14'h0011] = 8'h55;
        run_dump(14'h0010, 2, 2, 5, 0);

        // address wrap
        mem[14'h3FFE] = 8'h11;
        mem[14'h3FFF] = 8'h22;
        mem[14'h0000] = 8'h33;
        run_dump(14'h3FFE, 3, 0, 0, 0);

        // zero length
        run_dump(14'h0123, 0, 0, 0, 0);

        // second start during SEND is ignored
        for (int i = 0; i < 3; i++) mem[14'h0200 + i] = DATA_W'(8'hC0 + i);
        run_dump(14'h0200, 3, 0, 0, 1);

        // start in the DONE cycle is ignored
        run_dump(14'h0200, 2, 1, 0, 2);

        // reset during WAIT aborts the dump
        base_addr = 14'h0200;
        len = (ADDR_W+1)'(3);
        start = 1'b1;
        bus.tx_ready = 1'b1;
        tick();
        start = 1'b0;
        tick();
        @(negedge clk);
        check("pre_abort_state", dbg_state, WAIT);
        rst = 1'b1;
        @(negedge clk);
        check("abort_rd_en", bus.rd_en, 0);
        check("abort_rd_addr", bus.rd_addr, 0);
        check("abort_tx_data", bus.tx_data, 0);
        check("abort_tx_valid", bus.tx_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_quiet_done", done, 0);
            check("abort_quiet_valid", bus.tx_valid, 0);
        end
        bus.tx_ready = 1'b0;
        run_dump(14'h0200, 3, 0, 0, 0);

        // checksum bytes (trailer only when CHECKSUM_EN is defined)
        mem[14'h0300] = 8'hF0;
        mem[14'h0301] = 8'h20;
        run_dump(14'h0300, 2, 0, 0, 0);

        // randomized dumps
        for (int t = 0; t < 15; t++) begin
            logic [ADDR_W-1:0] rb;
            int rn;
            rb = ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
            rn = $urandom_range(0, 10);
            for (int i = 0; i < rn; i++) mem[ADDR_W'(rb + ADDR_W'(i))] = DATA_W'($urandom);
            run_dump(rb, rn, $urandom_range(0, 2), $urandom_range(0, 3), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/result_stream_reader.md
Name: result_stream_reader

Overview:
- Reader for the systolic array's result memory.
- After the array writes results (we/ws/result) and pulses finish, this block reads a contiguous address range back through a one-cycle-latency synchronous read port.
- It streams each byte out on a valid/ready interface to the UART transmitter.
- It sits between the result RAM read port and the UART TX path.

Parameters:
- ADDR_W, 14, address width of the result memory (matches the array's ws/read_select width).
- DATA_W, 8, data width of memory words and TX bytes.
- RD_LAT, 1, memory read latency in cycles; only 1 is supported, and other values are flagged by an elaboration-time check.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse, typically tied to the array's finish; begins a dump.
- base_addr  input  ADDR_W  first address to read; latched on an accepted start.
- len  input  ADDR_W+1  number of words to read (0..2^ADDR_W); latched on an accepted start.
- rd_en  output  1  memory read strobe.
- rd_addr  output  ADDR_W  memory read address.
- rd_data  input  DATA_W  memory read data; valid RD_LAT cycles after rd_en.
- tx_data  output  DATA_W  byte to the UART transmitter.
- tx_valid  output  1  tx_data valid.
- tx_ready  input  1  transmitter accepts the byte when tx_valid && tx_ready.
- busy  output  1  high from the accepted start until done.
- done  output  1  one-cycle pulse when the dump completes.

Behaviour:
- Reset: all outputs 0 (rd_en, rd_addr, tx_data, tx_valid, busy, done); FSM to IDLE; counters cleared. Reset mid-dump aborts immediately: no done pulse and no further TX.
- FSM states: IDLE, READ, WAIT, SEND, DONE.
- IDLE:
  - start=1 latches base_addr into the address counter and len into the remaining counter, and sets busy=1.
  - If len==0, go to DONE; otherwise go to READ.
  - start=0 stays in IDLE.
- READ: rd_en=1 and rd_addr=current address for exactly one cycle; go to WAIT.
- WAIT: rd_en=0. On the next edge, capture rd_data into tx_data, set tx_valid=1, and go to SEND.
- SEND:
  - tx_valid and tx_data are held stable until tx_ready=1.
  - On the handshake: address+1 (wraps modulo 2^ADDR_W, e.g. 0x3FFF -> 0x0000), remaining-1, tx_valid=0.
  - If remaining was 1, go to DONE; otherwise go to READ.
- DONE: done=1 for one cycle, busy=0 on exit; return to IDLE.
- Throughput: at most one byte per 3 cycles. Minimum latency from start to first tx_valid is 3 cycles.
- start while busy is ignored; no re-latch, no queueing.
- start in the same cycle as the DONE pulse is ignored. A new start is accepted from IDLE only.
- tx_ready asserted while tx_valid=0 has no effect.
- len=2^ADDR_W reads the whole memory once, starting at base_addr and wrapping.

Optional Feature:
- Macro CHECKSUM_EN.
- When defined:
  - An 8-bit running sum (mod 256) of every byte sent is kept; it is cleared on an accepted start.
  - After the last data handshake, the FSM enters state CSUM: tx_data=sum, tx_valid=1, held until tx_ready, then DONE.
  - For len==0 a single trailer byte 0x00 is sent.
- When undefined: no CSUM state, no sum register, no trailer byte.

Decomposition:
- Package systol_pkg holds:
  - ADDR_W=14 and DATA_W=8 constants, shared with systol_new1.
  - The reader state encoding constants (IDLE, READ, WAIT, SEND, DONE, CSUM).
- No sub-module is needed. The FSM, counters and TX hold register are a single flat module of roughly 150-250 lines.

Test Plan:
- Basic dump: memory holds mem[i]=i+1 for i=0..3; base=0, len=4, tx_ready tied 1 -> TX bytes 0x01,0x02,0x03,0x04; first tx_valid 3 cycles after start; done pulse once; busy low after.
- Backpressure: len=2, mem[0x10]=0xAA, mem[0x11]=0x55; tx_ready low 5 cycles per byte -> tx_data is stable while valid, bytes are 0xAA then 0x55, and there is exactly one rd_en per byte.
- Wrap and zero length:
  - base=0x3FFE, len=3 -> rd_addr sequence 0x3FFE, 0x3FFF, 0x0000.
  - len=0 -> no rd_en, no tx_valid, done one cycle after start.
- Ignored start and reset abort:
  - A second start during SEND (len=3) has no effect: exactly 3 bytes are sent.
  - rst=1 during WAIT -> all outputs 0 the next cycle, no done, and a subsequent start works normally.
- CHECKSUM_EN:
  - Bytes 0xF0, 0x20 -> trailer 0x10, then done.
  - Without the macro, the same stimulus gives 2 bytes only.
